// File: rtl/VX_gpu_pkg.sv
// -----------------------------------------------------------------------------
// VX_gpu_pkg
// Shared definitions for the dcache tag tracker slice:
//   - mem_tag_width() : derives the narrow memory-side tag width from the
//                       number of outstanding read slots.
//   - DEF_NUM_ENTRIES / DEF_MEM_TAG_WIDTH : default slot count and its tag width.
//   - mem_tag_id_t    : outstanding-ID type for the default configuration.
// -----------------------------------------------------------------------------
package VX_gpu_pkg;

  // A single-entry tracker still needs a 1-bit tag port.
  function automatic int mem_tag_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  localparam int DEF_NUM_ENTRIES   = 8;
  localparam int DEF_MEM_TAG_WIDTH = mem_tag_width(DEF_NUM_ENTRIES);

  typedef logic [DEF_MEM_TAG_WIDTH-1:0] mem_tag_id_t;

endpackage

// File: rtl/vx_mem_tag_tracker_chk.sv
// -----------------------------------------------------------------------------
// vx_mem_tag_tracker_chk
// Simulation-only property checks for the tag tracker.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_full       : allocator full flag
//   i_pending    : outstanding read count
//   i_alloc      : read allocation this cycle
//   i_rsp_fire   : memory response handshake this cycle
//   i_free_hit   : the returning ID was allocated
// -----------------------------------------------------------------------------
module vx_mem_tag_tracker_chk #(
  parameter int NUM_ENTRIES = 8,
  parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 i_full,
  input logic [CNT_WIDTH-1:0] i_pending,
  input logic                 i_alloc,
  input logic                 i_rsp_fire,
  input logic                 i_free_hit
);

  a_full_iff_pending_max : assert property (@(posedge clk) disable iff (reset)
    (i_pending == CNT_WIDTH'(NUM_ENTRIES)) == i_full);

  a_no_alloc_when_full : assert property (@(posedge clk) disable iff (reset)
    !(i_alloc && i_full));

  a_rsp_tag_allocated : assert property (@(posedge clk) disable iff (reset)
    i_rsp_fire |-> i_free_hit);

endmodule

// File: rtl/vx_tag_alloc.sv
// -----------------------------------------------------------------------------
// vx_tag_alloc
// Outstanding-ID allocator: valid bitmap, lowest-free priority encoder,
// full flag and outstanding count.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   i_alloc        : take the ID presented on o_alloc_id this cycle
//   i_free         : release i_free_id this cycle
//   i_free_id      : ID being released
//   o_alloc_id     : lowest-index free ID (0 when full)
//   o_full         : every ID is in use (registered state only)
//   o_pending      : number of IDs in use
//   o_free_hit     : the ID being released was actually allocated
// -----------------------------------------------------------------------------
module vx_tag_alloc
  import VX_gpu_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int ID_WIDTH    = mem_tag_width(NUM_ENTRIES),
  parameter int CNT_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_alloc,
  input  logic                 i_free,
  input  logic [ID_WIDTH-1:0]  i_free_id,
  output logic [ID_WIDTH-1:0]  o_alloc_id,
  output logic                 o_full,
  output logic [CNT_WIDTH-1:0] o_pending,
  output logic                 o_free_hit
);

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [CNT_WIDTH-1:0]   r_pending;
  logic [ID_WIDTH-1:0]    w_alloc_id;
  logic [NUM_ENTRIES-1:0] w_set_mask;
  logic [NUM_ENTRIES-1:0] w_clr_mask;
  logic                   w_free_hit;

  // Lowest-index clear bit; scanning downward lets the last hit win.
  always_comb begin
    w_alloc_id = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      w_alloc_id = r_valid[i] ? w_alloc_id : ID_WIDTH'(i);
    end
  end

  // Releasing an ID that was never allocated must not disturb the bitmap
  // or the count.
  assign w_free_hit = i_free & r_valid[i_free_id];
  assign w_set_mask = i_alloc    ? (NUM_ENTRIES'(1'b1) << w_alloc_id) : '0;
  assign w_clr_mask = w_free_hit ? (NUM_ENTRIES'(1'b1) << i_free_id)  : '0;

  // Valid bitmap and outstanding counter; alloc and free in one cycle cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_pending <= '0;
    end else begin
      r_valid <= (r_valid | w_set_mask) & ~w_clr_mask;
      case ({i_alloc, w_free_hit})
        2'b10:   r_pending <= r_pending + CNT_WIDTH'(1'b1);
        2'b01:   r_pending <= r_pending - CNT_WIDTH'(1'b1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign o_alloc_id = w_alloc_id;
  assign o_full     = &r_valid;
  assign o_pending  = r_pending;
  assign o_free_hit = w_free_hit;

endmodule

// File: rtl/vx_mem_tag_tracker.sv
// -----------------------------------------------------------------------------
// vx_mem_tag_tracker
// Single-lane adapter between a core dcache port and a memory port with a
// narrow tag. Reads get a small outstanding ID; the wide core tag is parked
// in a table and restored when the response returns through a one-entry
// response register. Writes pass straight through with tag 0.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   core_req_*           : core request (valid/ready, rw, byteen, addr, flags, data, tag)
//   core_rsp_*           : core response (valid/ready, data, restored tag)
//   mem_req_*            : forwarded request, tag replaced by the allocated ID
//   mem_rsp_*            : memory response (valid/ready, data, ID)
//   pending              : outstanding read count
//   busy                 : reads outstanding or a response held
// -----------------------------------------------------------------------------
module vx_mem_tag_tracker
  import VX_gpu_pkg::*;
#(
  parameter int WORD_SIZE      = 4,
  parameter int ADDR_WIDTH     = 30,
  parameter int FLAGS_WIDTH    = 1,
  parameter int CORE_TAG_WIDTH = 16,
  parameter int NUM_ENTRIES    = 8,
  parameter int MEM_TAG_WIDTH  = mem_tag_width(NUM_ENTRIES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               core_req_valid,
  input  logic                               core_req_rw,
  input  logic [WORD_SIZE-1:0]               core_req_byteen,
  input  logic [ADDR_WIDTH-1:0]              core_req_addr,
  input  logic [FLAGS_WIDTH-1:0]             core_req_flags,
  input  logic [WORD_SIZE*8-1:0]             core_req_data,
  input  logic [CORE_TAG_WIDTH-1:0]          core_req_tag,
  output logic                               core_req_ready,
  output logic                               core_rsp_valid,
  output logic [WORD_SIZE*8-1:0]             core_rsp_data,
  output logic [CORE_TAG_WIDTH-1:0]          core_rsp_tag,
  input  logic                               core_rsp_ready,
  output logic                               mem_req_valid,
  output logic                               mem_req_rw,
  output logic [WORD_SIZE-1:0]               mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr,
  output logic [FLAGS_WIDTH-1:0]             mem_req_flags,
  output logic [WORD_SIZE*8-1:0]             mem_req_data,
  output logic [MEM_TAG_WIDTH-1:0]           mem_req_tag,
  input  logic                               mem_req_ready,
  input  logic                               mem_rsp_valid,
  input  logic [WORD_SIZE*8-1:0]             mem_rsp_data,
  input  logic [MEM_TAG_WIDTH-1:0]           mem_rsp_tag,
  output logic                               mem_rsp_ready,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   pending,
  output logic                               busy
);

  localparam int PEND_WIDTH = $clog2(NUM_ENTRIES + 1);

  logic                      w_full;
  logic                      w_req_open;
  logic                      w_alloc;
  logic                      w_rsp_fire;
  logic                      w_free_hit;
  logic [MEM_TAG_WIDTH-1:0]  w_alloc_id;
  logic [PEND_WIDTH-1:0]     w_pending;

  logic [CORE_TAG_WIDTH-1:0] r_tag_table [NUM_ENTRIES];
  logic                      r_rsp_valid;
  logic [WORD_SIZE*8-1:0]    r_rsp_data;
  logic [CORE_TAG_WIDTH-1:0] r_rsp_tag;

  // Writes never need an ID, so only reads are throttled by a full table.
  assign w_req_open     = core_req_rw | ~w_full;
  assign mem_req_valid  = core_req_valid & w_req_open;
  assign core_req_ready = mem_req_ready & w_req_open;
  assign w_alloc        = core_req_valid & core_req_ready & ~core_req_rw;

  assign mem_req_rw     = core_req_rw;
  assign mem_req_byteen = core_req_byteen;
  assign mem_req_addr   = core_req_addr;
  assign mem_req_flags  = core_req_flags;
  assign mem_req_data   = core_req_data;
  assign mem_req_tag    = core_req_rw ? '0 : w_alloc_id;

  // The response register may take a new beat whenever it is empty or draining.
  assign mem_rsp_ready  = ~r_rsp_valid | core_rsp_ready;
  assign w_rsp_fire     = mem_rsp_valid & mem_rsp_ready;

  vx_tag_alloc #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ID_WIDTH    (MEM_TAG_WIDTH),
    .CNT_WIDTH   (PEND_WIDTH)
  ) u_alloc (
    .clk        (clk),
    .reset      (reset),
    .i_alloc    (w_alloc),
    .i_free     (w_rsp_fire),
    .i_free_id  (mem_rsp_tag),
    .o_alloc_id (w_alloc_id),
    .o_full     (w_full),
    .o_pending  (w_pending),
    .o_free_hit (w_free_hit)
  );

  // Tag table: contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag_table[w_alloc_id] <= core_req_tag;
    end else begin
      r_tag_table[w_alloc_id] <= r_tag_table[w_alloc_id];
    end
  end

  // One-entry response register; a stale tag is still forwarded so the core
  // never stalls on a protocol error downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end else if (w_rsp_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= mem_rsp_data;
      r_rsp_tag   <= r_tag_table[mem_rsp_tag];
    end else if (core_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign core_rsp_valid = r_rsp_valid;
  assign core_rsp_data  = r_rsp_data;
  assign core_rsp_tag   = r_rsp_tag;
  assign pending        = w_pending;
  assign busy           = (w_pending != '0) | r_rsp_valid;

  vx_mem_tag_tracker_chk #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .CNT_WIDTH   (PEND_WIDTH)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .i_full     (w_full),
    .i_pending  (w_pending),
    .i_alloc    (w_alloc),
    .i_rsp_fire (w_rsp_fire),
    .i_free_hit (w_free_hit)
  );

endmodule

// File: tb/tb_vx_mem_tag_tracker.sv
// -----------------------------------------------------------------------------
// tb_vx_mem_tag_tracker
// Self-checking bench: a reference model of the ID bitmap, tag table and
// response register predicts every handshake; returned responses are matched
// against a scoreboard queue filled when the memory response is driven.
// -----------------------------------------------------------------------------
module tb_vx_mem_tag_tracker;
  import VX_gpu_pkg::*;

  localparam int WS  = 4;
  localparam int AW  = 30;
  localparam int FW  = 1;
  localparam int CTW = 16;
  localparam int NE  = 8;
  localparam int MTW = 3;
  localparam int PW  = 4;

  logic              clk;
  logic              reset;
  logic              core_req_valid;
  logic              core_req_rw;
  logic [WS-1:0]     core_req_byteen;
  logic [AW-1:0]     core_req_addr;
  logic [FW-1:0]     core_req_flags;
  logic [WS*8-1:0]   core_req_data;
  logic [CTW-1:0]    core_req_tag;
  logic              core_req_ready;
  logic              core_rsp_valid;
  logic [WS*8-1:0]   core_rsp_data;
  logic [CTW-1:0]    core_rsp_tag;
  logic              core_rsp_ready;
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [WS-1:0]     mem_req_byteen;
  logic [AW-1:0]     mem_req_addr;
  logic [FW-1:0]     mem_req_flags;
  logic [WS*8-1:0]   mem_req_data;
  mem_tag_id_t       mem_req_tag;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [WS*8-1:0]   mem_rsp_data;
  mem_tag_id_t       mem_rsp_tag;
  logic              mem_rsp_ready;
  logic [PW-1:0]     pending;
  logic              busy;

  vx_mem_tag_tracker #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .FLAGS_WIDTH(FW),
    .CORE_TAG_WIDTH(CTW), .NUM_ENTRIES(NE)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
    .core_req_flags(core_req_flags), .core_req_data(core_req_data),
    .core_req_tag(core_req_tag), .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_flags(mem_req_flags), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .pending(pending), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [CTW-1:0]  tag;
    logic [WS*8-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  // Reference model state
  logic [NE-1:0]  m_valid;
  logic [CTW-1:0] m_table [NE];
  logic           m_rsp_valid;

  logic           g_rdy;
  mem_tag_id_t    g_mtag;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Response monitor: sampled mid-cycle, when the upcoming edge's handshake is settled.
  always @(negedge clk) begin
    #2;
    if (!reset && core_rsp_valid && core_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got tag 0x%0h, want no response", core_rsp_tag);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_tag", 64'(core_rsp_tag), 64'(e.tag));
        check("rsp_data", 64'(core_rsp_data), 64'(e.data));
      end
    end
  end

  // One clock cycle, entered and left at a falling edge.
  task automatic do_cycle(input string nm,
                          input logic rv, input logic rw, input logic [CTW-1:0] tag,
                          input logic [AW-1:0] addr, input logic mrdy,
                          input logic sv, input logic [MTW-1:0] stag,
                          input logic [WS*8-1:0] sdata, input logic crdy,
                          output logic o_rdy, output logic [MTW-1:0] o_mtag);
    logic           full;
    logic           exp_rdy;
    logic           exp_mrr;
    logic           fire;
    logic [MTW-1:0] exp_id;
    int             cnt;
    core_req_valid  = rv;
    core_req_rw     = rw;
    core_req_tag    = tag;
    core_req_addr   = addr;
    core_req_data   = {tag, ~tag};
    core_req_byteen = tag[WS-1:0];
    core_req_flags  = tag[FW-1:0];
    mem_req_ready   = mrdy;
    mem_rsp_valid   = sv;
    mem_rsp_tag     = stag;
    mem_rsp_data    = sdata;
    core_rsp_ready  = crdy;
    #1;
    full   = 1'b1;
    exp_id = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (!m_valid[i]) begin
        full   = 1'b0;
        exp_id = MTW'(i);
      end
    end
    exp_rdy = mrdy & (rw | ~full);
    exp_mrr = ~m_rsp_valid | crdy;
    fire    = sv & exp_mrr;
    check({nm, ".core_req_ready"}, 64'(core_req_ready), 64'(exp_rdy));
    check({nm, ".mem_req_valid"}, 64'(mem_req_valid), 64'(rv & (rw | ~full)));
    check({nm, ".mem_rsp_ready"}, 64'(mem_rsp_ready), 64'(exp_mrr));
    if (rv && (rw || !full)) begin
      check({nm, ".mem_req_tag"}, 64'(mem_req_tag), rw ? 64'(0) : 64'(exp_id));
      check({nm, ".payload"}, 64'({mem_req_rw, mem_req_byteen, mem_req_flags, mem_req_addr}),
            64'({rw, tag[WS-1:0], tag[FW-1:0], addr}));
      check({nm, ".wdata"}, 64'(mem_req_data), 64'({tag, ~tag}));
    end
    o_rdy  = core_req_ready;
    o_mtag = mem_req_tag;
    // free reads the table before this cycle's allocation can write it
    if (fire) begin
      exp_q.push_back('{m_table[stag], sdata});
      m_valid[stag] = 1'b0;
      m_rsp_valid   = 1'b1;
    end else if (crdy) begin
      m_rsp_valid = 1'b0;
    end
    if (rv && exp_rdy && !rw) begin
      m_valid[exp_id] = 1'b1;
      m_table[exp_id] = tag;
    end
    @(negedge clk);
    cnt = $countones(m_valid);
    check({nm, ".pending"}, 64'(pending), 64'(cnt));
    check({nm, ".busy"}, 64'(busy), 64'((cnt != 0) | m_rsp_valid));
    check({nm, ".core_rsp_valid"}, 64'(core_rsp_valid), 64'(m_rsp_valid));
  endtask

  task automatic idle(input logic crdy);
    do_cycle("idle", 1'b0, 1'b0, 16'h0000, 30'h0, 1'b1, 1'b0, 3'd0, 32'h0, crdy, g_rdy, g_mtag);
  endtask

  typedef struct {
    logic           rv;
    logic           rw;
    logic [CTW-1:0] tag;
    logic           exp_rdy;
    logic [MTW-1:0] exp_mtag;
    logic [PW-1:0]  exp_pend;
  } vec_t;
  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b0, CTW'(16'h00A0 + i), 1'b1, MTW'(i), PW'(i + 1)};
    end
    vecs[8] = '{1'b1, 1'b0, 16'h00A8, 1'b0, 3'd0, 4'd8};
    vecs[9] = '{1'b1, 1'b1, 16'h0BEE, 1'b1, 3'd0, 4'd8};

    reset = 1'b1;
    core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_byteen = '0;
    core_req_addr = '0; core_req_flags = '0; core_req_data = '0; core_req_tag = '0;
    core_rsp_ready = 1'b1; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
    m_valid = '0; m_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.core_rsp_valid", 64'(core_rsp_valid), 64'(0));
    check("reset.core_rsp_data", 64'(core_rsp_data), 64'(0));
    check("reset.core_rsp_tag", 64'(core_rsp_tag), 64'(0));
    check("reset.pending", 64'(pending), 64'(0));
    check("reset.busy", 64'(busy), 64'(0));
    reset = 1'b0;

    // single read then its response
    do_cycle("t1_read", 1'b1, 1'b0, 16'h1234, 30'h100, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, g_rdy, g_mtag);
    check("t1.mtag", 64'(g_mtag), 64'(0));
    check("t1.pending", 64'(pending), 64'(1));
    do_cycle("t1_rsp", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd0, 32'hDEADBEEF, 1'b1, g_rdy, g_mtag);
    check("t1.rsp_valid", 64'(core_rsp_valid), 64'(1));
    check("t1.rsp_tag", 64'(core_rsp_tag), 64'(16'h1234));
    check("t1.rsp_data", 64'(core_rsp_data), 64'(32'hDEADBEEF));
    check("t1.pending0", 64'(pending), 64'(0));
    idle(1'b1);

    // fill every slot, then a blocked read and an unblocked write
    for (int i = 0; i < 10; i++) begin
      do_cycle("t2_vec", vecs[i].rv, vecs[i].rw, vecs[i].tag, AW'(30'h200 + i), 1'b1,
               1'b0, 3'd0, 32'h0, 1'b1, g_rdy, g_mtag);
      check("t2.ready", 64'(g_rdy), 64'(vecs[i].exp_rdy));
      if (vecs[i].exp_rdy) check("t2.mtag", 64'(g_mtag), 64'(vecs[i].exp_mtag));
      check("t2.pending", 64'(pending), 64'(vecs[i].exp_pend));
    end

    // free ID 5 while a read waits: stalled this cycle, gets ID 5 next cycle
    do_cycle("t3_free", 1'b1, 1'b0, 16'h00B0, 30'h300, 1'b1, 1'b1, 3'd5, 32'h5555_0005, 1'b1, g_rdy, g_mtag);
    check("t3.stalled", 64'(g_rdy), 64'(0));
    do_cycle("t3_alloc", 1'b1, 1'b0, 16'h00B0, 30'h300, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, g_rdy, g_mtag);
    check("t3.ready", 64'(g_rdy), 64'(1));
    check("t3.mtag", 64'(g_mtag), 64'(5));
    check("t3.pending", 64'(pending), 64'(8));

    // out-of-order returns, one per cycle
    do_cycle("t4_r3", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd3, 32'h3333_0003, 1'b1, g_rdy, g_mtag);
    do_cycle("t4_r0", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd0, 32'h3333_0000, 1'b1, g_rdy, g_mtag);
    do_cycle("t4_r7", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd7, 32'h3333_0007, 1'b1, g_rdy, g_mtag);
    check("t4.pending", 64'(pending), 64'(5));
    idle(1'b1);

    // backpressure from the core holds the register and blocks memory
    do_cycle("t5_load", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd1, 32'h1111_0001, 1'b0, g_rdy, g_mtag);
    for (int k = 0; k < 5; k++) begin
      do_cycle("t5_hold", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd2, 32'h2222_0002, 1'b0, g_rdy, g_mtag);
      check("t5.hold_tag", 64'(core_rsp_tag), 64'(16'h00A1));
      check("t5.hold_data", 64'(core_rsp_data), 64'(32'h1111_0001));
    end
    do_cycle("t5_release", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd2, 32'h2222_0002, 1'b1, g_rdy, g_mtag);
    check("t5.next_tag", 64'(core_rsp_tag), 64'(16'h00A2));
    idle(1'b1);

    // reach 4 outstanding with a held response, then reset mid-cycle
    do_cycle("t6_rdC0", 1'b1, 1'b0, 16'h00C0, 30'h400, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, g_rdy, g_mtag);
    check("t6.mtag0", 64'(g_mtag), 64'(0));
    do_cycle("t6_rdC1", 1'b1, 1'b0, 16'h00C1, 30'h401, 1'b1, 1'b1, 3'd4, 32'h4444_0004, 1'b0, g_rdy, g_mtag);
    check("t6.mtag1", 64'(g_mtag), 64'(1));
    check("t6.pending4", 64'(pending), 64'(4));
    core_req_valid = 1'b0; mem_rsp_valid = 1'b0; core_rsp_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("t6.rst_rsp_valid", 64'(core_rsp_valid), 64'(0));
    check("t6.rst_rsp_data", 64'(core_rsp_data), 64'(0));
    check("t6.rst_rsp_tag", 64'(core_rsp_tag), 64'(0));
    check("t6.rst_pending", 64'(pending), 64'(0));
    check("t6.rst_busy", 64'(busy), 64'(0));
    m_valid = '0;
    m_rsp_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    do_cycle("t6_post", 1'b1, 1'b0, 16'h00D0, 30'h500, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, g_rdy, g_mtag);
    check("t6.post_mtag", 64'(g_mtag), 64'(0));
    do_cycle("t6_postrsp", 1'b0, 1'b0, 16'h0, 30'h0, 1'b1, 1'b1, 3'd0, 32'h0D0D_0D0D, 1'b1, g_rdy, g_mtag);
    repeat (3) idle(1'b1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_mem_tag_tracker.md
Name: vx_mem_tag_tracker

Overview:
- Single-lane adapter between one core data-cache request/response port and a downstream memory port that accepts only a narrow tag.
- On each read it allocates a small outstanding-ID, stores the core's wide tag in a table, and forwards the request with the ID as its tag.
- On a response it restores the wide tag and returns the data through a one-entry response register. Writes pass through untracked.
- One instance per dcache lane, placed directly below the core top-level dcache outputs.

Parameters:
- WORD_SIZE, 4, bytes per data word
- ADDR_WIDTH, 30, word-address width
- FLAGS_WIDTH, 1, request flag width
- CORE_TAG_WIDTH, 16, core-side tag width
- NUM_ENTRIES, 8, maximum outstanding reads (power of 2, >=2)
- MEM_TAG_WIDTH, $clog2(NUM_ENTRIES), memory-side tag width (derived, do not override)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- core_req_valid  in  1  request valid
- core_req_rw  in  1  1=write, 0=read
- core_req_byteen  in  WORD_SIZE  byte enables
- core_req_addr  in  ADDR_WIDTH  word address
- core_req_flags  in  FLAGS_WIDTH  request flags
- core_req_data  in  WORD_SIZE*8  write data
- core_req_tag  in  CORE_TAG_WIDTH  core tag
- core_req_ready  out  1  request accepted
- core_rsp_valid  out  1  response valid
- core_rsp_data  out  WORD_SIZE*8  read data
- core_rsp_tag  out  CORE_TAG_WIDTH  restored core tag
- core_rsp_ready  in  1  core accepts response
- mem_req_valid  out  1  forwarded request valid
- mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_flags, mem_req_data  out  as core side  forwarded unchanged
- mem_req_tag  out  MEM_TAG_WIDTH  allocated ID; 0 for writes
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  WORD_SIZE*8  read data
- mem_rsp_tag  in  MEM_TAG_WIDTH  ID of returning read
- mem_rsp_ready  out  1  tracker accepts response
- pending  out  $clog2(NUM_ENTRIES+1)  outstanding read count
- busy  out  1  pending!=0 or core_rsp_valid

Behaviour:
- Reset (async, active-high):
  - valid bitmap = 0; pending = 0.
  - core_rsp_valid = 0; core_rsp_data = 0; core_rsp_tag = 0.
  - busy = 0; table contents are don't-care.
- Request path is combinational, zero added latency:
  - full = &valid (registered state only).
  - mem_req_valid = core_req_valid & (rw | ~full).
  - core_req_ready = mem_req_ready & (rw | ~full).
  - Request payload is passed through unchanged.
- Allocation:
  - Occurs on a read handshake (core_req_valid & core_req_ready & ~rw).
  - The chosen ID is the lowest-index clear bit of valid.
  - mem_req_tag = that ID, driven in the same cycle as the request.
  - On the clock edge: valid[ID] <= 1 and table[ID] <= core_req_tag.
- Write handshake: no allocation; mem_req_tag = 0; pending unchanged.
- Response path:
  - mem_rsp_ready = ~core_rsp_valid | core_rsp_ready.
  - On a mem response handshake the register loads data and table[mem_rsp_tag], sets core_rsp_valid, and clears valid[mem_rsp_tag].
  - Latency is 1 cycle from mem handshake to core_rsp_valid.
  - If core_rsp_ready & ~new handshake, core_rsp_valid <= 0.
  - Back-to-back responses sustain 1 per cycle while core_rsp_ready=1.
  - While core_rsp_valid=1 and core_rsp_ready=0, the register holds stable and mem_rsp_ready=0.
- Simultaneous allocation and free in one cycle:
  - Both take effect; pending unchanged.
  - full is computed before the free, so a slot freed this cycle is first allocatable next cycle.
  - Allocating the same ID being freed is impossible, since an allocation only selects a clear bit.
- pending = popcount-equivalent counter:
  - +1 on allocation, -1 on free, net 0 when both occur.
  - Saturates at neither end by construction.
- Response with an unallocated tag:
  - Simulation assertion fires.
  - The response is still accepted and forwarded (the table value is stale); the valid bit stays 0 and pending does not decrement.
- Assertions: pending==NUM_ENTRIES iff full; no allocation while full.

Decomposition:
- Shared package (VX_gpu_pkg): MEM_TAG_WIDTH derivation and typedef mem_tag_id_t.
- Sub-module vx_tag_alloc holds the valid bitmap, the lowest-free priority encoder, full and pending.
  - Inputs: alloc, free, free_id.
  - Outputs: alloc_id, full, pending.
- Tag table: NUM_ENTRIES x CORE_TAG_WIDTH flop array, written on allocation and read asynchronously by mem_rsp_tag.

Test Plan:
- After reset, single read (tag 0x1234, addr 0x100) with mem_req_ready=1 → mem_req_tag=0, pending=1; mem response tag 0, data 0xDEADBEEF → next cycle core_rsp_valid=1, tag 0x1234, data 0xDEADBEEF, pending=0.
- Issue 8 reads (tags 0xA0..0xA7) with no responses → IDs 0..7, pending=8, core_req_ready=0 for a 9th read; a write in the same cycle is accepted with mem_req_tag=0.
- With 8 outstanding, return ID 5 while a read is pending → that read is stalled in the free cycle and allocated ID 5 in the next cycle; returned core tag 0xA5.
- Out-of-order returns 3,0,7 with core_rsp_ready=1 → core tags 0xA3,0xA0,0xA7 on consecutive cycles, mem_rsp_ready stays 1.
- Hold core_rsp_ready=0 with a response in the register → mem_rsp_ready=0, register stable for 5 cycles; release → delivered, next mem response accepted the same cycle.
- Assert reset mid-stream with 4 outstanding and core_rsp_valid=1 → outputs clear immediately (async), pending=0, busy=0; the first post-reset read gets ID 0.
